// File: rtl/iq_pll_sequencer_pkg.sv
// Shared definitions for the PLL bring-up / QPSK symbol sequencer.
package iq_pll_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    // Mid-scale of the offset-binary DAC inputs (idle level).
    localparam logic [7:0] IQ_MID = 8'h80;

    // Bit positions inside the 2-bit QPSK symbol.
    localparam int SYM_I_BIT = 1;
    localparam int SYM_Q_BIT = 0;

    // A set sign bit drives below mid-scale, a clear one drives above it.
    function automatic logic [7:0] qpsk_level(input logic neg, input logic [7:0] amp);
        return neg ? (IQ_MID - amp) : (IQ_MID + amp);
    endfunction

endpackage

// File: rtl/iq_pll_sequencer_qpsk_map.sv
// Combinational QPSK symbol to I/Q level mapper.
module qpsk_map
    import iq_pll_sequencer_pkg::*;
(
    input  logic [1:0] sym,
    input  logic [7:0] amp,
    output logic [7:0] i,
    output logic [7:0] q
);

    logic [7:0] lvl [2];

    // One level per symbol bit; bit index selects the rail.
    for (genvar gi = 0; gi < 2; gi++) begin : g_lvl
        assign lvl[gi] = qpsk_level(sym[gi], amp);
    end

    assign i = lvl[SYM_I_BIT];
    assign q = lvl[SYM_Q_BIT];

endmodule

// File: rtl/iq_pll_sequencer.sv
// PLL bring-up sequencer with lock timeout/retry and fixed-rate QPSK symbol feed.
module iq_pll_sequencer
    import iq_pll_sequencer_pkg::*;
#(
    parameter int unsigned ARESET_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT  = 4096,
    parameter int unsigned SETTLE_CYCLES = 256,
    parameter int unsigned SYM_PERIOD    = 8,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter logic [7:0]  AMP           = 8'h7f
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       locked,
    input  logic       sym_valid,
    input  logic [1:0] sym_data,
    input  logic       err_clear,
    output logic       sym_ready,
    output logic       pllena,
    output logic       areset,
    output logic [7:0] i,
    output logic [7:0] q,
    output logic       running,
    output logic       fault,
    output logic       lock_lost,
    output logic       underrun
);

    localparam int unsigned CNT_MAX = (ARESET_CYCLES > LOCK_TIMEOUT)
        ? ((ARESET_CYCLES > SETTLE_CYCLES) ? ARESET_CYCLES : SETTLE_CYCLES)
        : ((LOCK_TIMEOUT  > SETTLE_CYCLES) ? LOCK_TIMEOUT  : SETTLE_CYCLES);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int RW = $clog2(MAX_RETRIES + 2);
    localparam int TW = $clog2(SYM_PERIOD);

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [RW-1:0]   retry_reg, retry_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic            sync1_reg, lk_reg;
    logic            sym_ready_next;
    logic [7:0]      i_next, q_next, map_i, map_q;
    logic            lost_set, accept, starve;

    qpsk_map u_map (
        .sym (sym_data),
        .amp (AMP),
        .i   (map_i),
        .q   (map_q)
    );

    // Next state, counters and registered output values.
    always_comb begin
        state_next = state_reg;
        retry_next = retry_reg;
        lost_set   = 1'b0;
        accept     = 1'b0;
        starve     = 1'b0;
        case (state_reg)
            ST_HOLD: begin
                if (cnt_reg == CW'(ARESET_CYCLES - 1)) state_next = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // Lock takes priority over a simultaneous timeout.
                if (lk_reg) begin
                    state_next = ST_SETTLE;
                end else if (cnt_reg == CW'(LOCK_TIMEOUT - 1)) begin
                    retry_next = retry_reg + RW'(1);
                    state_next = (retry_reg == RW'(MAX_RETRIES)) ? ST_FAULT : ST_HOLD;
                end
            end
            ST_SETTLE: begin
                if (!lk_reg) begin
                    state_next = ST_HOLD;
                    lost_set   = 1'b1;
                end else if (cnt_reg == CW'(SETTLE_CYCLES - 1)) begin
                    state_next = ST_RUN;
                    retry_next = '0;
                end
            end
            ST_RUN: begin
                // Lock loss suppresses any symbol hand-off in the same cycle.
                if (!lk_reg) begin
                    state_next = ST_HOLD;
                    lost_set   = 1'b1;
                end else if (sym_ready) begin
                    accept = sym_valid;
                    starve = !sym_valid;
                end
            end
            ST_FAULT: begin
                if (err_clear) begin
                    state_next = ST_HOLD;
                    retry_next = '0;
                end
            end
            default: state_next = ST_HOLD;
        endcase

        // Counter restarts on every state change; only timed states advance it.
        cnt_next = '0;
        if (state_next == state_reg &&
            (state_reg == ST_HOLD || state_reg == ST_WAIT_LOCK || state_reg == ST_SETTLE))
            cnt_next = cnt_reg + CW'(1);

        timer_next = '0;
        if (state_reg == ST_RUN && state_next == ST_RUN)
            timer_next = (timer_reg == TW'(SYM_PERIOD - 1)) ? '0 : timer_reg + TW'(1);

        sym_ready_next = (state_next == ST_RUN) && (timer_next == TW'(SYM_PERIOD - 1));

        i_next = i;
        q_next = q;
        if (state_next != ST_RUN || starve) begin
            i_next = IQ_MID;
            q_next = IQ_MID;
        end else if (accept) begin
            i_next = map_i;
            q_next = map_q;
        end
    end

    // State, counters, lock synchroniser and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_HOLD;
            cnt_reg   <= '0;
            retry_reg <= '0;
            timer_reg <= '0;
            sync1_reg <= 1'b0;
            lk_reg    <= 1'b0;
            sym_ready <= 1'b0;
            pllena    <= 1'b1;
            areset    <= 1'b1;
            i         <= IQ_MID;
            q         <= IQ_MID;
            running   <= 1'b0;
            fault     <= 1'b0;
            lock_lost <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            retry_reg <= retry_next;
            timer_reg <= timer_next;
            sync1_reg <= locked;
            lk_reg    <= sync1_reg;
            sym_ready <= sym_ready_next;
            pllena    <= (state_next != ST_FAULT);
            areset    <= (state_next == ST_HOLD) || (state_next == ST_FAULT);
            i         <= i_next;
            q         <= q_next;
            running   <= (state_next == ST_RUN);
            fault     <= (state_next == ST_FAULT);
            lock_lost <= lost_set ? 1'b1 : (err_clear ? 1'b0 : lock_lost);
            underrun  <= starve   ? 1'b1 : (err_clear ? 1'b0 : underrun);
        end
    end

endmodule
